// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues requests and the slave side returns results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// using a full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic d;
  logic nb;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign d  = sa[0] ^ sb[0] ^ br;
  assign nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            br     <= bus.bin;
            cnt    <= '0;
            diff_q <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          diff_q <= {d, diff_q[WIDTH-1:1]};
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          br     <= nb;
          cnt    <= cnt + 1'b1;
          // The final borrow is captured from the same cell evaluation as the MSB.
          if (cnt == LAST) begin
            bout_q <= nb;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep checks for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   acceptedStarts;
  int   doneSeen;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) doneSeen++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives a request at a negedge and returns at the next negedge, start dropped.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic binv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = binv;
    @(negedge clk);
    bus.start = 1'b0;
    acceptedStarts++;
  endtask

  task automatic waitDone(input string tag, output int busyCycles);
    bit seen;
    busyCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busyCycles++;
      @(negedge clk);
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic binv, input logic [WIDTH-1:0] expDiff, input logic expBout,
                       input int expBusy);
    int cycles;
    applyStimulus(av, bv, binv);
    waitDone(tag, cycles);
    checkOutput({tag, "_diff"}, 32'(bus.diff), 32'(expDiff));
    checkOutput({tag, "_bout"}, 32'(bus.bout), 32'(expBout));
    if (expBusy >= 0) checkOutput({tag, "_busycyc"}, 32'(cycles), 32'(expBusy));
  endtask

  initial begin
    int cycles;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbin;
    logic [WIDTH:0]   ref9;

    vectors = 0;
    miscompares = 0;
    acceptedStarts = 0;
    doneSeen = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_diff", 32'(bus.diff), 32'd0);
    checkOutput("rst_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic subtraction");
    runOp("t1", 8'd5, 8'd3, 1'b0, 8'h02, 1'b0, 8);
    @(negedge clk);
    checkOutput("t1_donepulse", 32'(bus.done), 32'd0);
    checkOutput("t1_idlebusy", 32'(bus.busy), 32'd0);

    $display("[TB] borrow cases");
    runOp("t2a", 8'd3, 8'd5, 1'b0, 8'hFE, 1'b1, 8);
    @(negedge clk);
    runOp("t2b", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 8);
    @(negedge clk);

    $display("[TB] back-to-back");
    runOp("t3a", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8);
    applyStimulus(8'h80, 8'h01, 1'b0);
    checkOutput("t3_b2b_busy", 32'(bus.busy), 32'd1);
    checkOutput("t3_b2b_done", 32'(bus.done), 32'd0);
    checkOutput("t3_b2b_clr", 32'(bus.diff), 32'd0);
    waitDone("t3b", cycles);
    checkOutput("t3b_diff", 32'(bus.diff), 32'h7F);
    checkOutput("t3b_bout", 32'(bus.bout), 32'd0);
    checkOutput("t3b_busycyc", 32'(cycles), 32'd8);
    @(negedge clk);

    $display("[TB] start while busy");
    applyStimulus(8'd10, 8'd4, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd0;
    bus.b = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("t4", cycles);
    checkOutput("t4_diff", 32'(bus.diff), 32'h06);
    checkOutput("t4_bout", 32'(bus.bout), 32'd0);
    checkOutput("t4_busycyc", 32'(cycles), 32'd5);
    @(negedge clk);
    checkOutput("t4_norestart", 32'(bus.busy), 32'd0);
    checkOutput("t4_diffhold", 32'(bus.diff), 32'h06);

    $display("[TB] reset mid-operation");
    applyStimulus(8'd9, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_done", 32'(bus.done), 32'd0);
    checkOutput("t5_diff", 32'(bus.diff), 32'd0);
    checkOutput("t5_bout", 32'(bus.bout), 32'd0);
    acceptedStarts--;
    repeat (2) @(negedge clk);
    checkOutput("t5_holdbusy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    runOp("t5r", 8'd9, 8'd2, 1'b0, 8'h07, 1'b0, 8);
    @(negedge clk);

    $display("[TB] random sweep");
    for (int n = 0; n < 1000; n++) begin
      ra   = WIDTH'($urandom_range(0, 255));
      rb   = WIDTH'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      ref9 = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
      runOp("rnd", ra, rb, rbin, ref9[WIDTH-1:0], ref9[WIDTH], 8);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checkOutput("done_count", 32'(doneSeen), 32'(acceptedStarts));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
